// File: rtl/div_pkg.sv
// Shared types and constants for the 16-by-8 sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int DIV_STEPS  = 8;
    localparam int CNT_W      = 3;
    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;

endpackage

// File: rtl/cla_adder_8bit.sv
// 8-bit carry-lookahead adder with carry-in and carry-out.
module cla_adder_8bit (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    always_comb begin
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        // Carry recurrence; each c[i+1] flattens to a sum of generate/propagate terms.
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum  = p ^ c[7:0];
        cout = c[8];
    end

endmodule

// File: rtl/div_trial_sub_9bit.sv
// Trial subtraction t - d (9-bit minus 8-bit) for one restoring-division step.
module div_trial_sub_9bit (
    input  logic [8:0] t,
    input  logic [7:0] d,
    output logic [7:0] diff,
    output logic       no_borrow
);

    logic c7;

    cla_adder_8bit u_lo (
        .x    (t[7:0]),
        .y    (~d),
        .cin  (1'b1),
        .sum  (diff),
        .cout (c7)
    );

    // MSB stage adds t[8] + 1 + c7; its carry is the no-borrow flag. When there is
    // no borrow the difference is below d, so only the low 8 bits are returned.
    assign no_borrow = t[8] | c7;

endmodule

// File: rtl/divider_16bit_8by8_seq.sv
// Sequential restoring divider, 16-bit / 8-bit, one quotient bit per clock.
// Optional DIV_OVERFLOW_CHECK_EN: flags b==0 or a[15:8]>=b with err and a 1-cycle result.
module divider_16bit_8by8_seq
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] a,
    input  logic [DIVISOR_W-1:0]  b,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            q,
    output logic [7:0]            r,
    output logic                  err,
    output logic [1:0]            state_dbg
);

    // Handshake: start is accepted on any rising edge where busy is low (IDLE or FIN);
    // busy stays high through the 8 RUN steps, and done pulses for exactly one cycle
    // when q/r/err become valid. busy and done are never high together.

    state_t         state;
    logic [7:0]     prem;
    logic [7:0]     dshift;
    logic [7:0]     dvs;
    logic [CNT_W-1:0] cnt;

    logic [8:0]     t;
    logic [7:0]     diff;
    logic           no_borrow;
    logic [7:0]     prem_nxt;
    logic           accept;

    // prem[8] is always shifted out before it is ever read, so only 8 bits are kept.
    assign t         = {prem, dshift[7]};
    assign prem_nxt  = no_borrow ? diff : t[7:0];
    assign accept    = start & ~busy;
    assign state_dbg = state;

    div_trial_sub_9bit u_sub (
        .t         (t),
        .d         (dvs),
        .diff      (diff),
        .no_borrow (no_borrow)
    );

`ifdef DIV_OVERFLOW_CHECK_EN
    logic ovf;
    assign ovf = (b == 8'h00) || (a[15:8] >= b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= ovf;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            q      <= 8'h00;
            r      <= 8'h00;
            prem   <= 8'h00;
            dshift <= 8'h00;
            dvs    <= 8'h00;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                prem   <= a[15:8];
                dshift <= a[7:0];
                dvs    <= b;
                cnt    <= '0;
                q      <= 8'h00;
                r      <= 8'h00;
`ifdef DIV_OVERFLOW_CHECK_EN
                if (ovf) begin
                    state <= FIN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    q     <= 8'hFF;
                    r     <= a[7:0];
                end else begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
`else
                state <= RUN;
                busy  <= 1'b1;
`endif
            end else begin
                case (state)
                    RUN: begin
                        prem   <= prem_nxt;
                        dshift <= {dshift[6:0], 1'b0};
                        q      <= {q[6:0], no_borrow};
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_W'(DIV_STEPS - 1)) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            r     <= prem_nxt;
                        end
                    end
                    FIN:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_divider_16bit_8by8_seq.sv
// Self-checking bench for divider_16bit_8by8_seq (default and DIV_OVERFLOW_CHECK_EN builds).
module tb_divider_16bit_8by8_seq;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        err;
    logic [1:0]  state_dbg;

    logic [16:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          overlap = 0;

    divider_16bit_8by8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r),
        .err       (err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy === 1'b1 && done === 1'b1) overlap++;
    end

    // Expected {err, q, r} from plain integer division.
    function automatic logic [16:0] model(input logic [15:0] aa, input logic [7:0] bb);
        int qv;
        int rv;
        if (bb == 8'h00) begin
`ifdef DIV_OVERFLOW_CHECK_EN
            return {1'b1, 8'hFF, aa[7:0]};
`else
            return {1'b0, 8'hFF, aa[7:0]};
`endif
        end
`ifdef DIV_OVERFLOW_CHECK_EN
        if (aa[15:8] >= bb) return {1'b1, 8'hFF, aa[7:0]};
`endif
        qv = int'(aa) / int'(bb);
        rv = int'(aa) % int'(bb);
        return {1'b0, qv[7:0], rv[7:0]};
    endfunction

    // Start edge is consumed; returns at the negedge following it.
    task automatic issue(input logic [15:0] aa, input logic [7:0] bb);
        @(negedge clk);
        a = aa;
        b = bb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen (bounded).
    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = 16'h0;
        b = 8'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, q, r, err, state_dbg} !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'(IDLE)}) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b q=%h r=%h err=%b st=%0d, want all zero/IDLE",
                     busy, done, q, r, err, state_dbg);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_known();
        logic [15:0] ta[6] = '{16'd1000, 16'h1234, 16'hFE00, 16'h00FF, 16'h0000, 16'h7F80};
        logic [7:0]  tb[6] = '{8'd25,    8'h56,    8'hFF,    8'h01,    8'hFF,    8'h80};
        logic [7:0]  tq[6] = '{8'd40,    8'h36,    8'hFE,    8'hFF,    8'h00,    8'hFF};
        logic [7:0]  tr[6] = '{8'd0,     8'h10,    8'hFE,    8'h00,    8'h00,    8'h00};
        int edges;
        logic [16:0] e;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({1'b0, tq[i], tr[i]});
            issue(ta[i], tb[i]);
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL known_busy[%0d]: busy=%b want 1", i, busy);
            end
            wait_done(edges);
            n_cmp++;
            if (edges !== 8) begin
                n_err++;
                $display("FAIL known_latency[%0d]: edges=%0d want 8", i, edges);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if ({err, q, r} !== e) begin
                n_err++;
                $display("FAIL known_result[%0d]: err=%b q=%h r=%h want err=%b q=%h r=%h",
                         i, err, q, r, e[16], e[15:8], e[7:0]);
            end
            @(negedge clk);
            n_cmp++;
            if ({done, busy, q, r} !== {1'b0, 1'b0, e[15:8], e[7:0]}) begin
                n_err++;
                $display("FAIL known_hold[%0d]: done=%b busy=%b q=%h r=%h want 0 0 %h %h",
                         i, done, busy, q, r, e[15:8], e[7:0]);
            end
        end
    endtask

    task automatic test_random();
        int edges;
        logic [7:0]  bb;
        logic [7:0]  ah;
        logic [15:0] aa;
        logic [16:0] e;
        for (int i = 0; i < 8; i++) begin
            bb = 8'($urandom_range(1, 255));
            ah = 8'($urandom_range(0, int'(bb) - 1));
            aa = {ah, 8'($urandom_range(0, 255))};
            exp_q.push_back(model(aa, bb));
            issue(aa, bb);
            wait_done(edges);
            e = exp_q.pop_front();
            n_cmp++;
            if (edges !== 8 || {err, q, r} !== e) begin
                n_err++;
                $display("FAIL random[%0d] a=%h b=%h: edges=%0d err=%b q=%h r=%h want 8 %b %h %h",
                         i, aa, bb, edges, err, q, r, e[16], e[15:8], e[7:0]);
            end
        end
    endtask

    // Leaves the bench at the negedge of the FIN cycle of the first division.
    task automatic test_ignore_busy_start();
        logic [16:0] e;
        exp_q.push_back({1'b0, 8'd40, 8'd0});
        issue(16'd1000, 8'd25);
        for (int k = 1; k <= 8; k++) begin
            start = (k == 3 || k == 5);
            a = 16'hFFFF;
            b = 8'h03;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if ({done, err, q, r} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL ignore_busy: done=%b err=%b q=%h r=%h want 1 %b %h %h",
                     done, err, q, r, e[16], e[15:8], e[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        logic [16:0] e;
        a = 16'd200;
        b = 8'd7;
        start = 1'b1;
        exp_q.push_back({1'b0, 8'd28, 8'd4});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
        end
        wait_done(edges);
        e = exp_q.pop_front();
        n_cmp++;
        if (edges !== 8 || {err, q, r} !== e) begin
            n_err++;
            $display("FAIL b2b_result: edges=%0d err=%b q=%h r=%h want 8 %b %h %h",
                     edges, err, q, r, e[16], e[15:8], e[7:0]);
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        issue(16'd1000, 8'd25);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({busy, done, q, r, err, state_dbg} !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'(IDLE)}) begin
            n_err++;
            $display("FAIL abort_state: busy=%b done=%b q=%h r=%h err=%b st=%0d, want all zero/IDLE",
                     busy, done, q, r, err, state_dbg);
        end
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL abort_no_done: done pulses=%0d want 0", dones);
        end
    endtask

    task automatic test_div_zero();
        int edges;
        logic [16:0] e;
`ifdef DIV_OVERFLOW_CHECK_EN
        int want_edges = 0;
        exp_q.push_back({1'b1, 8'hFF, 8'hCD});
`else
        int want_edges = 8;
        exp_q.push_back({1'b0, 8'hFF, 8'hCD});
`endif
        issue(16'hABCD, 8'h00);
        wait_done(edges);
        e = exp_q.pop_front();
        n_cmp++;
        if (edges !== want_edges || {err, q, r} !== e) begin
            n_err++;
            $display("FAIL div_zero: edges=%0d err=%b q=%h r=%h want %0d %b %h %h",
                     edges, err, q, r, want_edges, e[16], e[15:8], e[7:0]);
        end
    endtask

`ifdef DIV_OVERFLOW_CHECK_EN
    task automatic test_overflow();
        int edges;
        logic [16:0] e;
        exp_q.push_back(model(16'h1000, 8'h10));
        issue(16'h1000, 8'h10);
        wait_done(edges);
        e = exp_q.pop_front();
        n_cmp++;
        if (edges !== 0 || {err, q, r} !== e || err !== 1'b1) begin
            n_err++;
            $display("FAIL overflow: edges=%0d err=%b q=%h r=%h want 0 1 %h %h",
                     edges, err, q, r, e[15:8], e[7:0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_known();
        test_random();
        test_ignore_busy_start();
        test_back_to_back();
        test_abort();
        test_div_zero();
`ifdef DIV_OVERFLOW_CHECK_EN
        test_overflow();
`endif
        n_cmp++;
        if (overlap !== 0) begin
            n_err++;
            $display("FAIL busy_done_overlap: cycles=%0d want 0", overlap);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL queue_drain: left=%0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
